// File: rtl/bcd_countdown_timer_pkg.sv
// Shared definitions for the BCD countdown timer: FSM state encodings and BCD helpers.
package bcd_countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic is_bcd(input logic [3:0] nibble);
    return (nibble <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control and status bundle between the board controller and the BCD countdown timer.
interface bcd_countdown_timer_if #(
  parameter int unsigned NUM_DIGITS = 4
);

  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_value;
  logic                    start;
  logic                    pause;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [1:0]              state;
  logic                    zero;
  logic                    done;
  logic                    load_err;

  modport master (
    output load, load_value, start, pause,
    input  digits, state, zero, done, load_err
  );

  modport slave (
    input  load, load_value, start, pause,
    output digits, state, zero, done, load_err
  );

endinterface

// File: rtl/bcd_down_digit.sv
// One BCD digit of a borrow-chained down-counter; wraps 0 -> 9 and passes a borrow upward.
module bcd_down_digit
  import bcd_countdown_timer_pkg::*;
(
  input  logic       clk_en_pulse,
  input  logic       reset_n,
  input  logic       load_i,
  input  logic [3:0] load_data_i,
  input  logic       dec_en_i,
  output logic [3:0] bcd_o,
  output logic       borrow_o
);

  logic [3:0] bcd_q, bcd_d;

  always_comb begin
    bcd_d = bcd_q;
    if (load_i) begin
      bcd_d = load_data_i;
    end else if (dec_en_i) begin
      bcd_d = (bcd_q == '0) ? BCD_MAX : bcd_q - 4'd1;
    end
  end

  always_ff @(posedge clk_en_pulse or negedge reset_n) begin
    if (!reset_n) begin
      bcd_q <= '0;
    end else begin
      bcd_q <= bcd_d;
    end
  end

  assign bcd_o    = bcd_q;
  assign borrow_o = dec_en_i && (bcd_q == '0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer: load/start/pause FSM over a chain of down-counting digits.
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                        clk_en_pulse,
  input  logic                        reset_n,
  bcd_countdown_timer_if.slave        bus
);

  localparam int unsigned W = 4 * NUM_DIGITS;

  state_e          state_q, state_d;
  logic            done_q, done_d;
  logic            load_err_q, load_err_d;
  logic            load_ok;
  logic            dig_load;
  logic            run_dec;
  logic [W-1:0]    digits_w;
  logic [NUM_DIGITS-1:0] borrow;
  logic            msd_borrow_unused;

  always_comb begin
    load_ok = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!is_bcd(bus.load_value[4*i +: 4])) begin
        load_ok = 1'b0;
      end
    end
  end

  assign dig_load = bus.load && load_ok;

  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;
    run_dec    = 1'b0;
    if (bus.load) begin
      if (load_ok) begin
        state_d = ST_IDLE;
      end else begin
        load_err_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start && !bus.pause && (digits_w != '0)) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.pause) begin
            state_d = ST_PAUSED;
          end else begin
            run_dec = 1'b1;
            // Count of 1 reaches zero on this edge, so RUN is left before any underflow.
            if (digits_w == W'(1)) begin
              state_d = ST_EXPIRED;
              done_d  = 1'b1;
            end
          end
        end
        ST_PAUSED: begin
          if (bus.start && !bus.pause) begin
            state_d = ST_RUN;
          end
        end
        ST_EXPIRED: begin
          state_d = ST_EXPIRED;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_en_pulse or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic dec_en;
    if (i == 0) begin : g_lsd
      assign dec_en = run_dec;
    end else begin : g_upper
      assign dec_en = borrow[i-1];
    end

    bcd_down_digit u_digit (
      .clk_en_pulse (clk_en_pulse),
      .reset_n      (reset_n),
      .load_i       (dig_load),
      .load_data_i  (bus.load_value[4*i +: 4]),
      .dec_en_i     (dec_en),
      .bcd_o        (digits_w[4*i +: 4]),
      .borrow_o     (borrow[i])
    );
  end

  // The top digit's borrow could only fire on underflow, which the FSM prevents.
  assign msd_borrow_unused = borrow[NUM_DIGITS-1];

  assign bus.digits   = digits_w;
  assign bus.state    = state_q;
  assign bus.zero     = (digits_w == '0);
  assign bus.done     = done_q;
  assign bus.load_err = load_err_q;

endmodule
